// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that sums two WIDTH-bit operands plus a
// carry-in, DIGIT bits per clock, through a ripple slice with a registered
// carry. Operands arrive and results leave through valid/ready handshakes.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the `sub` input, which
// turns the operation into a - b (carry=1 means no borrow).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (a, b, cin [, sub])
//   a, b              WIDTH-bit operands
//   cin               carry-in (ignored when sub=1)
//   sub               subtract select (only with SERIAL_ADDER_SUB_EN)
//   out_valid/out_ready result handshake
//   sum, carry        result modulo 2^WIDTH and carry-out of bit WIDTH-1
//   busy              high while an operation is in RUN or DONE
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned SW    = DIGIT + 1;

  // Elaboration-time parameter checks
  if (WIDTH < 1) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 1");
  end
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            in_ready_d, out_valid_d, busy_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;

  logic             accept_c;
  logic             last_c;
  logic [SW-1:0]    slice_c;
  logic [WIDTH-1:0] sum_shift_c;
  logic [WIDTH-1:0] b_load_c;
  logic             c_load_c;

  assign accept_c = in_valid && in_ready;
  assign last_c   = (cnt_q == CW'(STEPS - 1));

  // State register plus registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, taken from the next state so the outputs register cleanly
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      RUN:     busy_d      = 1'b1;
      DONE:    begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: in_ready_d  = 1'b1;
    endcase
  end

  // Operand conditioning at capture: subtraction is a + ~b + 1
  always_comb begin
    b_load_c = b;
    c_load_c = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_c = ~b;
      c_load_c = 1'b1;
    end
`endif
  end

  // One DIGIT-wide ripple slice; result digits enter sum from the MSB side
  always_comb begin
    slice_c     = SW'(a_q[DIGIT-1:0]) + SW'(b_q[DIGIT-1:0]) + SW'(c_q);
    sum_shift_c = WIDTH'({slice_c[DIGIT-1:0], sum} >> DIGIT);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            a_q   <= a;
            b_q   <= b_load_c;
            c_q   <= c_load_c;
            cnt_q <= '0;
            sum   <= '0;
            carry <= 1'b0;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          c_q   <= slice_c[DIGIT];
          sum   <= sum_shift_c;
          cnt_q <= cnt_q + CW'(1);
          if (last_c) carry <= slice_c[DIGIT];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (8/1, 8/4, 3/1) with a scoreboard
// queue per instance, a monitor per instance popping on each accepted result,
// and directed timing checks on the 8-bit, 1-bit-per-clock instance.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: WIDTH=8, DIGIT=1
  logic [7:0] a8, b8, s8;
  logic       cin8, iv8, ir8, ov8, or8, c8, bz8;
  // Instance 1: WIDTH=8, DIGIT=4
  logic [7:0] a4, b4, s4;
  logic       cin4, iv4, ir4, ov4, or4, c4, bz4;
  // Instance 2: WIDTH=3, DIGIT=1
  logic [2:0] a3, b3, s3;
  logic       cin3, iv3, ir3, ov3, or3, c3, bz3;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, sub4, sub3;
`endif

  // Expected {carry, sum} per instance
  logic [8:0] q8[$];
  logic [8:0] q4[$];
  logic [8:0] q3[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(c8), .busy(bz8));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .out_valid(ov4), .out_ready(or4), .sum(s4), .carry(c4), .busy(bz4));

  serial_adder #(.WIDTH(3), .DIGIT(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .cin(cin3),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub3),
`endif
    .out_valid(ov3), .out_ready(or3), .sum(s3), .carry(c3), .busy(bz3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive point: 2 time units after the active edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic get_ir(input int id);
    case (id)
      0:       return ir8;
      1:       return ir4;
      default: return ir3;
    endcase
  endfunction

  task automatic set_or(input int id, input logic v);
    case (id)
      0:       or8 = v;
      1:       or4 = v;
      default: or3 = v;
    endcase
  endtask

  // Reference: plain arithmetic on the operand width
  function automatic logic [8:0] model(input int w, input logic [7:0] a,
                                       input logic [7:0] b, input logic ci,
                                       input logic sb);
    int mask, av, bv, r;
    mask = (1 << w) - 1;
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    if (sb) begin
      r = (av - bv) & mask;
      return {(av >= bv), 8'(r)};
    end
    r = av + bv + int'(ci);
    return {((r >> w) & 1) != 0, 8'(r & mask)};
  endfunction

  // Issue one operation: wait for in_ready, present for one edge, push expected
  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb);
    for (int n = 0; n < 300 && !get_ir(id); n++) tick();
    chk($sformatf("in_ready_wait%0d", id), 32'(get_ir(id)), 32'd1);
    case (id)
      0: begin
        a8 = a; b8 = b; cin8 = ci; iv8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = sb;
`endif
        q8.push_back(model(8, a, b, ci, sb));
      end
      1: begin
        a4 = a; b4 = b; cin4 = ci; iv4 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub4 = sb;
`endif
        q4.push_back(model(8, a, b, ci, sb));
      end
      default: begin
        a3 = a[2:0]; b3 = b[2:0]; cin3 = ci; iv3 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub3 = sb;
`endif
        q3.push_back(model(3, a, b, ci, sb));
      end
    endcase
    tick();
    iv8 = 1'b0; iv4 = 1'b0; iv3 = 1'b0;
  endtask

  // Wait for the instance to return to IDLE, optionally jittering out_ready
  task automatic wait_idle(input int id, input bit jitter);
    for (int n = 0; n < 300 && !get_ir(id); n++) begin
      if (jitter) set_or(id, 1'($urandom_range(0, 1)));
      tick();
    end
    set_or(id, 1'b1);
    chk($sformatf("done_wait%0d", id), 32'(get_ir(id)), 32'd1);
  endtask

  // Scoreboard pop on every result handshake
  task automatic mon(input int id, input logic [7:0] s, input logic c);
    logic [8:0] e;
    int sz;
    case (id)
      0:       sz = q8.size();
      1:       sz = q4.size();
      default: sz = q3.size();
    endcase
    if (sz == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_result%0d: got sum=0x%0h carry=%0b, expected none", id, s, c);
    end else begin
      case (id)
        0:       e = q8.pop_front();
        1:       e = q4.pop_front();
        default: e = q3.pop_front();
      endcase
      chk($sformatf("sum%0d", id), 32'(s), 32'(e[7:0]));
      chk($sformatf("carry%0d", id), 32'(c), 32'(e[8]));
    end
  endtask

  always @(negedge clk) if (!rst && ov8 && or8) mon(0, s8, c8);
  always @(negedge clk) if (!rst && ov4 && or4) mon(1, s4, c4);
  always @(negedge clk) if (!rst && ov3 && or3) mon(2, {5'b0, s3}, c3);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sb;
    rst = 1'b1;
    iv8 = 0; iv4 = 0; iv3 = 0;
    or8 = 1; or4 = 1; or3 = 1;
    a8 = 0; b8 = 0; cin8 = 0; a4 = 0; b4 = 0; cin4 = 0; a3 = 0; b3 = 0; cin3 = 0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 0; sub4 = 0; sub3 = 0;
`endif
    tick();
    // Reset state
    chk("rst_in_ready", 32'(ir8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_busy", 32'(bz8), 32'd0);
    chk("rst_sum", 32'(s8), 32'd0);
    chk("rst_carry", 32'(c8), 32'd0);
    rst = 1'b0;
    tick();

    // Latency: 8 RUN cycles, in_ready low and busy high throughout
    send(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("lat_out_valid_low", 32'(ov8), 32'd0);
      chk("lat_in_ready_low", 32'(ir8), 32'd0);
      chk("lat_busy_high", 32'(bz8), 32'd1);
      tick();
    end
    chk("lat_out_valid", 32'(ov8), 32'd1);
    chk("lat_busy_done", 32'(bz8), 32'd1);
    wait_idle(0, 1'b0);

    send(0, 8'hA5, 8'h5A, 1'b1, 1'b0);
    wait_idle(0, 1'b0);
    send(0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_idle(0, 1'b0);

    // Backpressure: result held for 5 cycles, in_valid pulses ignored
    or8 = 1'b0;
    send(0, 8'h3C, 8'h0F, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !ov8; n++) tick();
    chk("bp_out_valid", 32'(ov8), 32'd1);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'(i % 2 == 0);
      a8 = 8'($urandom);
      tick();
      chk("bp_hold_valid", 32'(ov8), 32'd1);
      chk("bp_hold_sum", 32'(s8), 32'h4C);
      chk("bp_hold_carry", 32'(c8), 32'd0);
      chk("bp_in_ready", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    chk("bp_release_valid", 32'(ov8), 32'd0);
    chk("bp_release_ready", 32'(ir8), 32'd1);
    chk("bp_release_busy", 32'(bz8), 32'd0);
    chk("bp_sum_kept", 32'(s8), 32'h4C);

    // Reset three cycles into RUN aborts the operation
    send(0, 8'h12, 8'h34, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(ir8), 32'd1);
    chk("abort_out_valid", 32'(ov8), 32'd0);
    chk("abort_busy", 32'(bz8), 32'd0);
    chk("abort_sum", 32'(s8), 32'd0);
    chk("abort_carry", 32'(c8), 32'd0);
    q8.delete();
    tick();
    rst = 1'b0;
    tick();
    send(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_idle(0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    send(0, 8'h10, 8'h01, 1'b0, 1'b1);
    wait_idle(0, 1'b0);
    send(0, 8'h01, 8'h02, 1'b1, 1'b1);
    wait_idle(0, 1'b0);
    send(0, 8'hA5, 8'h5A, 1'b1, 1'b0);
    wait_idle(0, 1'b0);
`endif

    // Random operands with a jittering consumer
    for (int i = 0; i < 30; i++) begin
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom_range(0, 1));
`endif
      send(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), sb);
      wait_idle(0, 1'b1);
    end

    // DIGIT=4: two RUN cycles
    send(1, 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("d4_valid_0", 32'(ov4), 32'd0);
    tick();
    chk("d4_valid_1", 32'(ov4), 32'd0);
    tick();
    chk("d4_valid_2", 32'(ov4), 32'd1);
    wait_idle(1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom_range(0, 1));
`endif
      send(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), sb);
      wait_idle(1, 1'b1);
    end

    // WIDTH=3: exhaustive sweep
    for (int i = 0; i < 128; i++) begin
      send(2, 8'(i & 7), 8'((i >> 3) & 7), 1'((i >> 6) & 1), 1'b0);
      wait_idle(2, 1'b0);
    end

    tick(); tick();
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
